// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path.
//   btn_state_t : per-channel debounce FSM encoding
//   BTN_*       : channel index of each Basys3 button within the btn_* vectors
//   *_DEFAULT   : timing defaults for a 100 MHz clk
//   cnt_width() : counter width helper (never below one bit)
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW     = 2'd0,
    CONFIRM_HIGH = 2'd1,
    IDLE_HIGH    = 2'd2,
    CONFIRM_LOW  = 2'd3
  } btn_state_t;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam int NBTN_DEFAULT            = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;   // 10 ms
  localparam int HOLD_CYCLES_DEFAULT     = 50000000;  // 500 ms
  localparam int REPEAT_CYCLES_DEFAULT   = 10000000;  // 100 ms

  // Width able to hold 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered press
// pulse and write-1-to-clear sticky latch.
//
// Optional build macro: BTN_REPEAT_EN adds a hold counter that produces
// auto-repeat press pulses while the button stays on the high side.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   raw        asynchronous raw button pin
//   clr_sticky one-cycle clear strobe for sticky
//   level      debounced level
//   press      one-cycle pulse per accepted press (and per repeat)
//   sticky     set by press, cleared by clr_sticky; set wins
//
// state        | meaning
// -------------+----------------------------------------------------
// IDLE_LOW     | level accepted low, waiting for s2=1
// CONFIRM_HIGH | s2 high, counting stable samples before accepting 1
// IDLE_HIGH    | level accepted high, waiting for s2=0
// CONFIRM_LOW  | s2 low, counting stable samples before accepting 0
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BTN_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clr_sticky,
  output logic level,
  output logic press,
  output logic sticky
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt;
  logic             rise;
  logic             press_nxt;
  logic             sticky_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE_LOW;
    else       state <= state_nxt;
  end

  // The counter starts at 1 on entering a confirm state because the entry
  // sample itself already counts as the first stable sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise      = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_nxt = CONFIRM_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CONFIRM_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_nxt = CONFIRM_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      CONFIRM_LOW: begin
        if (s2) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              repeating, repeating_nxt;
  logic              rpt_fire;
  logic              high_now, high_next;

  // The entry edge into IDLE_HIGH is not counted, so the first repeat lands
  // exactly HOLD_CYCLES after the level rise. Repeats continue through
  // CONFIRM_LOW since the release is not yet accepted there.
  assign high_now  = (state == IDLE_HIGH) || (state == CONFIRM_LOW);
  assign high_next = (state_nxt == IDLE_HIGH) || (state_nxt == CONFIRM_LOW);

  always_comb begin
    hold_nxt      = '0;
    repeating_nxt = 1'b0;
    rpt_fire      = 1'b0;
    if (high_now && high_next) begin
      repeating_nxt = repeating;
      if (!repeating && hold_cnt == HOLD_LAST) begin
        rpt_fire      = 1'b1;
        repeating_nxt = 1'b1;
      end else if (repeating && hold_cnt == REP_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        hold_nxt = hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else begin
      hold_cnt  <= hold_nxt;
      repeating <= repeating_nxt;
    end
  end

  assign press_nxt = rise | rpt_fire;
`else
  assign press_nxt = rise;
`endif

  // A press on the same edge as a clear keeps the latch set.
  assign sticky_nxt = press_nxt | (sticky & ~clr_sticky);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      press  <= press_nxt;
      sticky <= sticky_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw Basys3 push-buttons (bit order C,U,L,R,D) for the MMIO
// block: each bit is handled by an independent debounce_channel.
//
// Optional build macro: BTN_REPEAT_EN enables hold-to-repeat press pulses;
// HOLD_CYCLES and REPEAT_CYCLES only take effect when it is defined.
//
// Ports:
//   clk        system clock (single domain)
//   reset      synchronous, active-high reset
//   btn_raw    [NBTN] asynchronous raw button pins
//   clr_sticky [NBTN] write-1-to-clear strobe for btn_sticky
//   btn_level  [NBTN] debounced level
//   btn_press  [NBTN] registered one-cycle press pulse
//   btn_sticky [NBTN] pressed since last clear
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NBTN            = NBTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  input  logic [NBTN-1:0] clr_sticky,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_sticky
);

  // The confirm counter relies on at least two stable samples.
  if (NBTN < 1 || DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter values");
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_REPEAT_EN
      ,
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .raw        (btn_raw[i]),
      .clr_sticky (clr_sticky[i]),
      .level      (btn_level[i]),
      .press      (btn_press[i]),
      .sticky     (btn_sticky[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] clr_sticky;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_sticky;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NBTN            (NB),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .clr_sticky (clr_sticky),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_sticky (btn_sticky)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    btn_raw    = 5'b00001;
    clr_sticky = '0;
    steps(3);
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL reset_level actual=%b required=%b", btn_level, 5'b0); end
    checks++; if (btn_press !== 5'b0) begin failures++; $display("FAIL reset_press actual=%b required=%b", btn_press, 5'b0); end
    checks++; if (btn_sticky !== 5'b0) begin failures++; $display("FAIL reset_sticky actual=%b required=%b", btn_sticky, 5'b0); end
    reset = 1'b0;
    steps(5);
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL reset_early_level actual=%b required=%b", btn_level, 5'b0); end
    step();
    checks++; if (btn_level !== 5'b00001) begin failures++; $display("FAIL reset_rise_level actual=%b required=%b", btn_level, 5'b00001); end
    checks++; if (btn_press !== 5'b00001) begin failures++; $display("FAIL reset_rise_press actual=%b required=%b", btn_press, 5'b00001); end
    checks++; if (btn_sticky !== 5'b00001) begin failures++; $display("FAIL reset_rise_sticky actual=%b required=%b", btn_sticky, 5'b00001); end
    step();
    checks++; if (btn_press !== 5'b0) begin failures++; $display("FAIL reset_press_width actual=%b required=%b", btn_press, 5'b0); end
    btn_raw = '0;
    steps(6);
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL reset_release_level actual=%b required=%b", btn_level, 5'b0); end
    clr_sticky = 5'b00001;
    step();
    clr_sticky = '0;
    checks++; if (btn_sticky !== 5'b0) begin failures++; $display("FAIL reset_clear_sticky actual=%b required=%b", btn_sticky, 5'b0); end
  endtask

  task automatic test_clean_press();
    int first = 0, pulses = 0, fall = 0, rel_pulses = 0;
    btn_raw[BTN_L] = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      step();
      if (btn_level[BTN_L] && first == 0) first = s;
      if (btn_press[BTN_L]) pulses++;
    end
    checks++; if (first !== 6) begin failures++; $display("FAIL clean_rise_step actual=%0d required=%0d", first, 6); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL clean_pulse_count actual=%0d required=%0d", pulses, 1); end
    btn_raw[BTN_L] = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      step();
      if (!btn_level[BTN_L] && fall == 0) fall = s;
      if (btn_press[BTN_L]) rel_pulses++;
    end
    checks++; if (fall !== 6) begin failures++; $display("FAIL clean_fall_step actual=%0d required=%0d", fall, 6); end
    checks++; if (rel_pulses !== 0) begin failures++; $display("FAIL clean_release_pulse actual=%0d required=%0d", rel_pulses, 0); end
    checks++; if (btn_sticky !== 5'b00100) begin failures++; $display("FAIL clean_sticky actual=%b required=%b", btn_sticky, 5'b00100); end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern = 4'b0101;
    int bounce_pulses = 0, bounce_high = 0, first = 0, pulses = 0;
    for (int k = 3; k >= 0; k--) begin
      btn_raw[BTN_U] = pattern[k] ^ 1'b1;
      for (int s = 0; s < 2; s++) begin
        step();
        if (btn_press[BTN_U]) bounce_pulses++;
        if (btn_level[BTN_U]) bounce_high++;
      end
    end
    btn_raw[BTN_U] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (btn_level[BTN_U] && first == 0) first = s;
      if (btn_press[BTN_U]) pulses++;
    end
    checks++; if (bounce_pulses !== 0) begin failures++; $display("FAIL bounce_pulses actual=%0d required=%0d", bounce_pulses, 0); end
    checks++; if (bounce_high !== 0) begin failures++; $display("FAIL bounce_level actual=%0d required=%0d", bounce_high, 0); end
    checks++; if (first !== 6) begin failures++; $display("FAIL bounce_rise_step actual=%0d required=%0d", first, 6); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL bounce_settle_pulses actual=%0d required=%0d", pulses, 1); end
    btn_raw[BTN_U] = 1'b0;
    steps(8);
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL bounce_release_level actual=%b required=%b", btn_level, 5'b0); end
  endtask

  task automatic test_sticky_clear();
    btn_raw[BTN_R] = 1'b1;
    steps(7);
    checks++; if (btn_sticky[BTN_R] !== 1'b1) begin failures++; $display("FAIL sticky_set actual=%b required=%b", btn_sticky[BTN_R], 1'b1); end
    clr_sticky = 5'b01000;
    step();
    clr_sticky = '0;
    checks++; if (btn_sticky !== 5'b00110) begin failures++; $display("FAIL sticky_clear actual=%b required=%b", btn_sticky, 5'b00110); end
    btn_raw[BTN_R] = 1'b0;
    steps(8);
    btn_raw[BTN_R] = 1'b1;
    steps(5);
    checks++; if (btn_press[BTN_R] !== 1'b0) begin failures++; $display("FAIL sticky_pre_press actual=%b required=%b", btn_press[BTN_R], 1'b0); end
    clr_sticky = 5'b01000;
    step();
    clr_sticky = '0;
    checks++; if (btn_press[BTN_R] !== 1'b1) begin failures++; $display("FAIL sticky_coinc_press actual=%b required=%b", btn_press[BTN_R], 1'b1); end
    checks++; if (btn_sticky[BTN_R] !== 1'b1) begin failures++; $display("FAIL sticky_set_wins actual=%b required=%b", btn_sticky[BTN_R], 1'b1); end
    step();
    checks++; if (btn_sticky[BTN_R] !== 1'b1) begin failures++; $display("FAIL sticky_hold actual=%b required=%b", btn_sticky[BTN_R], 1'b1); end
    btn_raw[BTN_R] = 1'b0;
    steps(8);
  endtask

  task automatic test_reset_mid_confirm();
    btn_raw[BTN_D] = 1'b1;
    steps(4);
    reset = 1'b1;
    step();
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL midrst_level actual=%b required=%b", btn_level, 5'b0); end
    checks++; if (btn_sticky !== 5'b0) begin failures++; $display("FAIL midrst_sticky actual=%b required=%b", btn_sticky, 5'b0); end
    step();
    checks++; if (btn_press !== 5'b0) begin failures++; $display("FAIL midrst_press actual=%b required=%b", btn_press, 5'b0); end
    reset = 1'b0;
    steps(5);
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL midrst_early_level actual=%b required=%b", btn_level, 5'b0); end
    step();
    checks++; if (btn_level !== 5'b10000) begin failures++; $display("FAIL midrst_rise_level actual=%b required=%b", btn_level, 5'b10000); end
    checks++; if (btn_press !== 5'b10000) begin failures++; $display("FAIL midrst_rise_press actual=%b required=%b", btn_press, 5'b10000); end
    btn_raw[BTN_D] = 1'b0;
    steps(8);
  endtask

  task automatic test_repeat();
    int  pulses = 0, bad_steps = 0, exp_pulses;
    bit  rep_en, exp_p;
`ifdef BTN_REPEAT_EN
    rep_en     = 1'b1;
    exp_pulses = 8;   // steps 6,16,19,22,25,28,31,34
`else
    rep_en     = 1'b0;
    exp_pulses = 1;
`endif
    btn_raw[BTN_C] = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      if (s == 31) btn_raw[BTN_C] = 1'b0;
      step();
      exp_p = (s == 6) || (rep_en && s >= 16 && s <= 35 && ((s - 16) % 3) == 0);
      if (btn_press[BTN_C]) pulses++;
      checks++;
      if (btn_press[BTN_C] !== exp_p) begin
        failures++; bad_steps++;
        $display("FAIL repeat_press_step%0d actual=%b required=%b", s, btn_press[BTN_C], exp_p);
      end
    end
    checks++; if (pulses !== exp_pulses) begin failures++; $display("FAIL repeat_pulse_count actual=%0d required=%0d", pulses, exp_pulses); end
    checks++; if (btn_level !== 5'b0) begin failures++; $display("FAIL repeat_release_level actual=%b required=%b", btn_level, 5'b0); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_sticky_clear();
    test_reset_mid_confirm();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
